// File: rtl/shift_scheduler.sv
// Round-robin scheduler sharing one 48-bit multi-pass shifter between two requesters.
// Optional completed-operation counters are enabled with SHIFT_SCHEDULER_STATS_EN.
module shift_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] a0,
    input  logic [23:0] a1,
    input  logic        mod0,
    input  logic        mod1,
    input  logic [4:0]  n0,
    input  logic [4:0]  n1,
    output logic        ack0,
    output logic        ack1,
    output logic        res_valid,
    output logic        res_id,
    output logic [47:0] res,
    input  logic        res_ready,
    output logic        busy,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    localparam int unsigned OP_W     = 24;
    localparam int unsigned RES_W    = 48;
    localparam int unsigned AMT_W    = 5;
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned STEP_MAX = 15;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [RES_W-1:0]    acc;
    logic [AMT_W-1:0]    rem;
    logic                dir;
    logic                id;
    logic                last;

    logic                grant;
    logic [OP_W-1:0]     sel_a;
    logic                sel_mod;
    logic [AMT_W-1:0]    sel_n;
    logic [STEP_W-1:0]   step;
    logic [AMT_W-1:0]    rem_next;
    logic [RES_W-1:0]    acc_shift;
    logic                take;
    logic                done_hs;

    // Arbitration and operand select; on a tie the requester not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last;
        end else if (req1) begin
            grant = 1'b1;
        end
        sel_a   = grant ? a1   : a0;
        sel_mod = grant ? mod1 : mod0;
        sel_n   = grant ? n1   : n0;
    end

    // One pass moves at most STEP_MAX positions.
    always_comb begin
        step      = (rem > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem[STEP_W-1:0];
        rem_next  = rem - AMT_W'(step);
        acc_shift = dir ? (acc >> step) : (acc << step);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        take       = 1'b0;
        done_hs    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    ack0       = ~grant;
                    ack1       = grant;
                    state_next = (sel_n != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (rem_next == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    done_hs    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one pass per SHIFT cycle, pointer moves on result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            rem       <= '0;
            dir       <= 1'b0;
            id        <= 1'b0;
            last      <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (take) begin
                acc <= {(RES_W - OP_W)'(0), sel_a};
                rem <= sel_n;
                dir <= sel_mod;
                id  <= grant;
            end else if (state == S_SHIFT) begin
                acc <= acc_shift;
                rem <= rem_next;
            end
            if (done_hs) begin
                last <= id;
            end
            res_valid <= (state_next == S_DONE);
            busy      <= (state_next != S_IDLE);
        end
    end

    assign res    = acc;
    assign res_id = id;

`ifdef SHIFT_SCHEDULER_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating per-requester completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (done_hs) begin
            if (!id && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (id && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = CNT_W'(0);
    assign cnt1 = CNT_W'(0);
`endif

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler: directed table, fairness, backpressure,
// reset mid-operation and random operations against a behavioural model.
module tb_shift_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [23:0] a0, a1;
    logic        mod0, mod1;
    logic [4:0]  n0, n1;
    logic        ack0, ack1;
    logic        res_valid;
    logic        res_id;
    logic [47:0] res;
    logic        res_ready;
    logic        busy;
    logic [15:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    // Model state
    logic mlast;
    int   mcnt0, mcnt1;

    always #5 clk = ~clk;

    shift_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .a1        (a1),
        .mod0      (mod0),
        .mod1      (mod1),
        .n0        (n0),
        .n1        (n1),
        .ack0      (ack0),
        .ack1      (ack1),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res       (res),
        .res_ready (res_ready),
        .busy      (busy),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    typedef struct {
        logic        id;
        logic [23:0] a;
        logic        mod;
        logic [4:0]  n;
        logic [47:0] exp_res;
        int          exp_lat;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model_res(input logic [23:0] a, input logic mod, input logic [4:0] n);
        logic [47:0] x;
        x = {24'd0, a};
        return mod ? (x >> n) : (x << n);
    endfunction

    function automatic int model_lat(input logic [4:0] n);
        int p;
        p = (int'(n) + 14) / 15;
        return p + 1;
    endfunction

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef SHIFT_SCHEDULER_STATS_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c > 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic model_done(input logic id);
        mlast = id;
        if (id) mcnt1++; else mcnt0++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt0"}, 48'(cnt0), 48'(exp_cnt(mcnt0)));
        check({tag, "_cnt1"}, 48'(cnt1), 48'(exp_cnt(mcnt1)));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic id, input logic [23:0] a, input logic mod, input logic [4:0] n,
                          input logic [47:0] exp_res, input int exp_lat, input int hold);
        int lat;
        int budget;
        if (id) begin req1 = 1'b1; a1 = a; mod1 = mod; n1 = n; end
        else    begin req0 = 1'b1; a0 = a; mod0 = mod; n0 = n; end
        #1;
        budget = 0;
        while (!(ack0 || ack1) && budget < 20) begin
            @(negedge clk); #1; budget++;
        end
        check("ack_seen", 48'(ack0 || ack1), 48'(1));
        check("ack_owner", 48'({ack1, ack0}), id ? 48'(2) : 48'(1));
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("ack_pulse", 48'({ack1, ack0}), 48'(0));
        lat = 1;
        while (!res_valid && lat < 12) begin
            @(negedge clk); #1; lat++;
        end
        check("latency", 48'(lat), 48'(exp_lat));
        check("res", res, exp_res);
        check("res_id", 48'(res_id), 48'(id));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (id) req0 = 1'b1; else req1 = 1'b1;
            #1;
            check("hold_stable", {res_valid, res_id, res[45:0]}, {1'b1, id, exp_res[45:0]});
            check("hold_no_ack", 48'({ack1, ack0}), 48'(0));
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        res_ready = 1'b1;
        #1;
        check("pre_hs_valid", 48'(res_valid), 48'(1));
        @(negedge clk);
        res_ready = 1'b0;
        model_done(id);
        #1;
        check("post_hs_idle", 48'({busy, res_valid}), 48'(0));
        check_counters("op");
    endtask

    // Both requesters hold req high with res_ready = 1; grants must alternate.
    task automatic fairness(input int nres);
        int   done;
        logic cur;
        logic [47:0] exp_r;
        done = 0;
        cur  = 1'b0;
        req0 = 1'b1; a0 = 24'h000001; mod0 = 1'b0; n0 = 5'd1;
        req1 = 1'b1; a1 = 24'h000003; mod1 = 1'b0; n1 = 5'd2;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && done < nres; cyc++) begin
            #1;
            if (ack0 || ack1) begin
                check("fair_grant", 48'({ack1, ack0}), mlast ? 48'(1) : 48'(2));
                cur = ack1;
            end
            if (res_valid) begin
                exp_r = cur ? model_res(a1, mod1, n1) : model_res(a0, mod0, n0);
                check("fair_res", res, exp_r);
                check("fair_res_id", 48'(res_id), 48'(cur));
                model_done(cur);
                done++;
                if (done == nres) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("fair_done", 48'(done), 48'(nres));
        req0 = 1'b0; req1 = 1'b0;
        res_ready = 1'b0;
        #1;
        check("fair_idle", 48'({busy, res_valid}), 48'(0));
        check_counters("fair");
    endtask

    vec_t vecs[7];

    initial begin
        logic seen;
        vecs[0] = '{1'b0, 24'h000001, 1'b0, 5'd20, 48'h000000100000, 3, 2};
        vecs[1] = '{1'b1, 24'hF00000, 1'b1, 5'd22, 48'h000000000003, 3, 0};
        vecs[2] = '{1'b0, 24'hFFFFFF, 1'b0, 5'd31, 48'hFFFF80000000, 4, 1};
        vecs[3] = '{1'b0, 24'h123456, 1'b0, 5'd0,  48'h000000123456, 1, 5};
        vecs[4] = '{1'b1, 24'hFFFFFF, 1'b1, 5'd24, 48'h000000000000, 3, 0};
        vecs[5] = '{1'b1, 24'h000001, 1'b0, 5'd15, 48'h000000008000, 2, 0};
        vecs[6] = '{1'b0, 24'h000001, 1'b0, 5'd16, 48'h000000010000, 3, 0};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; mod0 = 1'b0; mod1 = 1'b0; n0 = '0; n1 = '0;
        res_ready = 1'b0;
        mlast = 1'b1; mcnt0 = 0; mcnt1 = 0;

        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid", 48'(res_valid), 48'(0));
        check("rst_res", res, 48'(0));
        check("rst_id", 48'(res_id), 48'(0));
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_ack", 48'({ack1, ack0}), 48'(0));
        check("rst_cnt", {16'd0, cnt1, cnt0}, 48'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fairness(4);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].mod, vecs[i].n,
                   vecs[i].exp_res, vecs[i].exp_lat, vecs[i].hold);
        end

        for (int i = 0; i < 40; i++) begin
            logic        rid;
            logic [23:0] ra;
            logic        rmod;
            logic [4:0]  rn;
            rid  = 1'($urandom_range(0, 1));
            ra   = 24'($urandom);
            rmod = 1'($urandom_range(0, 1));
            rn   = 5'($urandom_range(0, 31));
            run_op(rid, ra, rmod, rn, model_res(ra, rmod, rn), model_lat(rn),
                   int'($urandom_range(0, 2)));
        end

        // Reset during SHIFT discards the in-flight result.
        req0 = 1'b1; a0 = 24'hFFFFFF; mod0 = 1'b0; n0 = 5'd31;
        #1;
        check("mid_ack", 48'(ack0), 48'(1));
        @(negedge clk);
        req0 = 1'b0;
        #1;
        check("mid_busy", 48'(busy), 48'(1));
        rst_n = 1'b0;
        #1;
        mlast = 1'b1; mcnt0 = 0; mcnt1 = 0;
        check("mid_rst_out", {res_valid, busy, res_id, ack1, ack0}, 48'(0));
        check("mid_rst_res", res, 48'(0));
        check("mid_rst_cnt", {16'd0, cnt1, cnt0}, 48'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (res_valid || busy) seen = 1'b1;
        end
        check("no_stale_result", 48'(seen), 48'(0));

        fairness(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
